// File: rtl/mac_pkg.sv
// Shared types for the MAC partial-sum path: result width and the in-flight tag.
package mac_pkg;

    localparam int unsigned MAC_RESULT_WIDTH = 18;

    typedef struct packed {
        logic fire;
        logic last;
    } tag_t;

endpackage

// File: rtl/mac_result_fifo.sv
// Synchronous FIFO holding completed dot products; exposes its occupancy for credit logic.
module mac_result_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign valid   = (count != '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & valid;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mac_partial_sum_accumulator.sv
// Accumulates MAC partial sums per dot product, saturating, with credit-based issue throttling.
module mac_partial_sum_accumulator
    import mac_pkg::*;
#(
    parameter int unsigned MAC_LATENCY    = 2,
    parameter int unsigned ACC_WIDTH      = 32,
    parameter int unsigned OUT_FIFO_DEPTH = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               issue_valid,
    input  logic                               issue_last,
    output logic                               issue_ready,
    input  logic signed [MAC_RESULT_WIDTH-1:0] mac_result,
    output logic signed [ACC_WIDTH-1:0]        out_data,
    output logic                               out_overflow,
    output logic                               out_valid,
    input  logic                               out_ready
);

    localparam int unsigned CNT_W = $clog2(OUT_FIFO_DEPTH + 1);
    localparam int unsigned SUM_W = ACC_WIDTH + 1;

    tag_t                 tag_q [MAC_LATENCY];
    tag_t                 tag_out;
    logic                 fire;
    logic [ACC_WIDTH-1:0] acc;
    logic                 ovf;
    logic                 first;
    logic [SUM_W-1:0]     acc_ext;
    logic [SUM_W-1:0]     mac_ext;
    logic [SUM_W-1:0]     sum_wide;
    logic [ACC_WIDTH-1:0] sum_sat;
    logic                 saturated;
    logic                 ovf_n;
    logic                 push;
    logic [CNT_W-1:0]     fifo_count;
    logic [ACC_WIDTH:0]   head;
    int unsigned          pending;

    assign fire    = issue_valid & issue_ready;
    assign tag_out = tag_q[MAC_LATENCY-1];
    assign push    = tag_out.fire & tag_out.last;

    // Tags track which MAC outputs belong to issued groups; last is only kept for real fires.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < MAC_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= '{fire: fire, last: fire & issue_last};
            for (int unsigned i = 1; i < MAC_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    // One extra bit of headroom is enough: |acc| and |mac_result| are each at most 2^(ACC_WIDTH-1).
    always_comb begin
        acc_ext   = first ? '0 : {acc[ACC_WIDTH-1], acc};
        mac_ext   = {{(SUM_W - MAC_RESULT_WIDTH){mac_result[MAC_RESULT_WIDTH-1]}}, mac_result};
        sum_wide  = acc_ext + mac_ext;
        saturated = (sum_wide[SUM_W-1] != sum_wide[SUM_W-2]);
        sum_sat   = sum_wide[ACC_WIDTH-1:0];
        if (saturated) begin
            sum_sat                = sum_wide[SUM_W-1] ? '0 : '1;
            sum_sat[ACC_WIDTH-1]   = sum_wide[SUM_W-1];
        end
        ovf_n = (first ? 1'b0 : ovf) | saturated;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc   <= '0;
            ovf   <= 1'b0;
            first <= 1'b1;
        end else if (tag_out.fire) begin
            if (tag_out.last) begin
                first <= 1'b1;
            end else begin
                acc   <= sum_sat;
                ovf   <= ovf_n;
                first <= 1'b0;
            end
        end
    end

    // Reserve a FIFO slot for every dot product whose last group is still in the MAC.
    always_comb begin
        pending = 32'(fifo_count);
        for (int unsigned i = 0; i < MAC_LATENCY; i++) begin
            pending = pending + 32'(tag_q[i].last);
        end
    end

    assign issue_ready = (pending < OUT_FIFO_DEPTH);

    mac_result_fifo #(
        .WIDTH (ACC_WIDTH + 1),
        .DEPTH (OUT_FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({sum_sat, ovf_n}),
        .pop       (out_ready),
        .head      (head),
        .valid     (out_valid),
        .count     (fifo_count)
    );

    assign out_data     = head[ACC_WIDTH:1];
    assign out_overflow = head[0];

endmodule

// File: tb/tb_mac_partial_sum_accumulator.sv
// Directed bench: a behavioural 4-lane MAC feeds two accumulators (ACC_WIDTH 32 and 20).
module tb_mac_partial_sum_accumulator;

    localparam int unsigned L = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        iv;
    logic        il;
    logic        sel20;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic        out_ready32;
    logic        out_ready20;
    logic signed [17:0] mac_pipe [L];
    logic signed [17:0] mac_result;

    logic        iv32;
    logic        iv20;
    logic        ir32;
    logic        ir20;
    logic signed [31:0] od32;
    logic signed [19:0] od20;
    logic        ovf32;
    logic        ovf20;
    logic        ov32;
    logic        ov20;

    int vectors;
    int errors;
    logic [32:0] q32 [$];
    logic [20:0] q20 [$];

    assign iv32       = iv & ~sel20;
    assign iv20       = iv & sel20;
    assign mac_result = mac_pipe[L-1];

    mac_partial_sum_accumulator #(.MAC_LATENCY(L), .ACC_WIDTH(32), .OUT_FIFO_DEPTH(2)) dut (
        .clk(clk), .reset(reset), .issue_valid(iv32), .issue_last(il), .issue_ready(ir32),
        .mac_result(mac_result), .out_data(od32), .out_overflow(ovf32), .out_valid(ov32),
        .out_ready(out_ready32)
    );

    mac_partial_sum_accumulator #(.MAC_LATENCY(L), .ACC_WIDTH(20), .OUT_FIFO_DEPTH(2)) dut20 (
        .clk(clk), .reset(reset), .issue_valid(iv20), .issue_last(il), .issue_ready(ir20),
        .mac_result(mac_result), .out_data(od20), .out_overflow(ovf20), .out_valid(ov20),
        .out_ready(out_ready20)
    );

    // Four identical lanes: result = 4 * a * b, signed, no stall and no reset like the real MAC.
    function automatic logic signed [17:0] mac_model(input logic [7:0] a, input logic [7:0] b);
        int p;
        p = 4 * int'($signed(a)) * int'($signed(b));
        return 18'(p);
    endfunction

    always @(posedge clk) begin
        mac_pipe[0] <= mac_model(op_a, op_b);
        for (int i = 1; i < int'(L); i++) begin
            mac_pipe[i] <= mac_pipe[i-1];
        end
    end

    // Record every accepted output word.
    always @(negedge clk) begin
        #1;
        if (!reset) begin
            if (ov32 && out_ready32) q32.push_back({od32, ovf32});
            if (ov20 && out_ready20) q20.push_back({od20, ovf20});
        end
    end

    // Called at a negedge; holds the group until the selected DUT accepts it, returns at the next negedge.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic last);
        int guard;
        guard = 0;
        op_a = a;
        op_b = b;
        iv   = 1'b1;
        il   = last;
        while (!(sel20 ? ir20 : ir32) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            vectors++;
            errors++;
            $display("FAIL issue_timeout: issue_ready stayed %0b, required 1", sel20 ? ir20 : ir32);
        end
        @(negedge clk);
        iv   = 1'b0;
        il   = 1'b0;
        op_a = 8'($urandom);
        op_b = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        idle(3);
        vectors++;
        if (ov32 !== 1'b0 || od32 !== 32'sd0 || ovf32 !== 1'b0) begin
            errors++;
            $display("FAIL reset_out32: valid=%0b data=%0d ovf=%0b, required 0 0 0", ov32, od32, ovf32);
        end
        vectors++;
        if (ir32 !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready32: got %0b required 1", ir32);
        end
        vectors++;
        if (ov20 !== 1'b0 || od20 !== 20'sd0 || ovf20 !== 1'b0) begin
            errors++;
            $display("FAIL reset_out20: valid=%0b data=%0d ovf=%0b, required 0 0 0", ov20, od20, ovf20);
        end
        vectors++;
        if (ir20 !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready20: got %0b required 1", ir20);
        end
        reset = 1'b0;
        idle(1);
        vectors++;
        if (ov32 !== 1'b0 || ir32 !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: valid=%0b ready=%0b, required 0 1", ov32, ir32);
        end
    endtask

    task automatic test_basic;
        logic [32:0] exp;
        q32.delete();
        issue(8'h01, 8'h01, 1'b0);
        issue(8'h01, 8'h01, 1'b0);
        issue(8'h01, 8'h01, 1'b1);
        vectors++;
        if (ov32 !== 1'b0) begin
            errors++;
            $display("FAIL basic_lat1: out_valid=%0b required 0", ov32);
        end
        idle(1);
        vectors++;
        if (ov32 !== 1'b0) begin
            errors++;
            $display("FAIL basic_lat2: out_valid=%0b required 0", ov32);
        end
        idle(1);
        vectors++;
        if (ov32 !== 1'b1 || od32 !== 32'sd12 || ovf32 !== 1'b0) begin
            errors++;
            $display("FAIL basic_lat3: valid=%0b data=%0d ovf=%0b, required 1 12 0", ov32, od32, ovf32);
        end
        idle(4);
        exp = {32'd12, 1'b0};
        vectors++;
        if (q32.size() != 1 || q32[0] !== exp) begin
            errors++;
            $display("FAIL basic_count: %0d outputs, required exactly 1 of 12", q32.size());
        end
    endtask

    task automatic test_signed;
        logic [32:0] exp [4];
        exp[0] = {32'd65536, 1'b0};
        exp[1] = {32'd65536, 1'b0};
        exp[2] = {32'd65536, 1'b0};
        exp[3] = {32'(-65024), 1'b0};
        q32.delete();
        issue(8'h80, 8'h80, 1'b1);
        issue(8'h80, 8'h80, 1'b1);
        issue(8'h80, 8'h80, 1'b1);
        issue(8'h80, 8'h7F, 1'b1);
        idle(6);
        vectors++;
        if (q32.size() != 4) begin
            errors++;
            $display("FAIL signed_count: got %0d outputs, required 4", q32.size());
        end
        for (int i = 0; i < 4 && i < q32.size(); i++) begin
            vectors++;
            if (q32[i] !== exp[i]) begin
                errors++;
                $display("FAIL signed_%0d: got %0d ovf %0b, required %0d ovf %0b", i,
                         $signed(q32[i][32:1]), q32[i][0], $signed(exp[i][32:1]), exp[i][0]);
            end
        end
    endtask

    task automatic test_saturation;
        logic [20:0] exp0;
        logic [20:0] exp1;
        exp0 = {20'd524287, 1'b1};
        exp1 = {20'd4, 1'b0};
        q20.delete();
        sel20 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            issue(8'h80, 8'h80, (i == 7));
        end
        issue(8'h01, 8'h01, 1'b1);
        idle(6);
        sel20 = 1'b0;
        vectors++;
        if (q20.size() != 2) begin
            errors++;
            $display("FAIL sat_count: got %0d outputs, required 2", q20.size());
        end
        if (q20.size() >= 2) begin
            vectors++;
            if (q20[0] !== exp0) begin
                errors++;
                $display("FAIL sat_value: got %0d ovf %0b, required 524287 ovf 1",
                         $signed(q20[0][20:1]), q20[0][0]);
            end
            vectors++;
            if (q20[1] !== exp1) begin
                errors++;
                $display("FAIL sat_sticky_clear: got %0d ovf %0b, required 4 ovf 0",
                         $signed(q20[1][20:1]), q20[1][0]);
            end
        end
    endtask

    task automatic test_backpressure;
        int fires;
        logic [32:0] exp0;
        logic [32:0] exp1;
        exp0 = {32'd4, 1'b0};
        exp1 = {32'd8, 1'b0};
        q32.delete();
        out_ready32 = 1'b0;
        fires = 0;
        for (int c = 0; c < 10; c++) begin
            op_a = 8'(fires + 1);
            op_b = 8'h01;
            iv   = 1'b1;
            il   = 1'b1;
            if (ir32) fires++;
            if (ov32) begin
                vectors++;
                if (od32 !== 32'sd4) begin
                    errors++;
                    $display("FAIL bp_head_stable: got %0d required 4 at cycle %0d", od32, c);
                end
            end
            @(negedge clk);
        end
        iv = 1'b0;
        il = 1'b0;
        vectors++;
        if (fires != 2) begin
            errors++;
            $display("FAIL bp_fires: got %0d fires, required 2", fires);
        end
        vectors++;
        if (ir32 !== 1'b0 || ov32 !== 1'b1) begin
            errors++;
            $display("FAIL bp_stalled: ready=%0b valid=%0b, required 0 1", ir32, ov32);
        end
        out_ready32 = 1'b1;
        vectors++;
        if (ir32 !== 1'b0) begin
            errors++;
            $display("FAIL bp_no_comb_credit: ready=%0b required 0", ir32);
        end
        @(negedge clk);
        out_ready32 = 1'b0;
        vectors++;
        if (ir32 !== 1'b1 || ov32 !== 1'b1 || od32 !== 32'sd8) begin
            errors++;
            $display("FAIL bp_after_pop: ready=%0b valid=%0b data=%0d, required 1 1 8", ir32, ov32, od32);
        end
        out_ready32 = 1'b1;
        idle(3);
        vectors++;
        if (q32.size() != 2 || q32[0] !== exp0 || q32[1] !== exp1) begin
            errors++;
            $display("FAIL bp_results: got %0d outputs, required exactly 4 then 8", q32.size());
        end
    endtask

    task automatic test_reset_mid;
        logic [32:0] exp;
        exp = {32'd4, 1'b0};
        q32.delete();
        issue(8'h01, 8'h01, 1'b0);
        issue(8'h01, 8'h01, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vectors++;
        if (ov32 !== 1'b0 || ir32 !== 1'b1) begin
            errors++;
            $display("FAIL midreset_state: valid=%0b ready=%0b, required 0 1", ov32, ir32);
        end
        issue(8'h01, 8'h01, 1'b1);
        idle(6);
        vectors++;
        if (q32.size() != 1 || q32[0] !== exp) begin
            errors++;
            $display("FAIL midreset_result: %0d outputs, first %0d, required exactly one 4",
                     q32.size(), (q32.size() > 0) ? $signed(q32[0][32:1]) : 0);
        end
    endtask

    task automatic test_idle_gaps;
        logic [32:0] exp;
        exp = {32'd24, 1'b0};
        q32.delete();
        issue(8'h02, 8'h01, 1'b0);
        idle(3);
        issue(8'h03, 8'h01, 1'b0);
        idle(2);
        issue(8'h01, 8'h01, 1'b1);
        idle(6);
        vectors++;
        if (q32.size() != 1 || q32[0] !== exp) begin
            errors++;
            $display("FAIL gaps_result: %0d outputs, first %0d, required exactly one 24",
                     q32.size(), (q32.size() > 0) ? $signed(q32[0][32:1]) : 0);
        end
    endtask

    initial begin
        vectors     = 0;
        errors      = 0;
        reset       = 1'b1;
        iv          = 1'b0;
        il          = 1'b0;
        sel20       = 1'b0;
        op_a        = 8'h00;
        op_b        = 8'h00;
        out_ready32 = 1'b1;
        out_ready20 = 1'b1;
        @(negedge clk);
        test_reset;
        test_basic;
        test_signed;
        test_saturation;
        test_backpressure;
        test_reset_mid;
        test_idle_gaps;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
